// File: rtl/core_if.sv
// Instruction/data bus between the core datapath and its unified memory.
interface core_if;
    logic [15:0] iaddr;
    logic [31:0] idata;
    logic [15:0] daddr;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    modport master (
        output iaddr,
        output daddr,
        output wdata,
        output wstrb,
        input  idata,
        input  rdata
    );

    modport slave (
        input  iaddr,
        input  daddr,
        input  wdata,
        input  wstrb,
        output idata,
        output rdata
    );
endinterface

// File: rtl/core.sv
// Single-cycle RV32I + Zicsr core with 64 KiB unified byte memory.
// Optional CORE_TRACE_EN prints a per-cycle execution trace.
module core_mem (
    input logic clk,
    core_if.slave bus
);
    logic [7:0]  m [0:65535];
    logic [15:0] ia [4];
    logic [15:0] da [4];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            ia[k] = bus.iaddr + 16'(k);
            da[k] = bus.daddr + 16'(k);
        end
    end

    assign bus.idata = {m[ia[3]], m[ia[2]], m[ia[1]], m[ia[0]]};
    assign bus.rdata = {m[da[3]], m[da[2]], m[da[1]], m[da[0]]};

    // Byte lanes let misaligned stores wrap around the 64 KiB space.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (bus.wstrb[k]) m[da[k]] <= bus.wdata[8*k +: 8];
        end
    end
endmodule

module core (
    input logic clk,
    input logic rst
);
    logic [31:0] pc;
    logic [31:0] rs  [0:31];
    logic [31:0] csr [0:4095];

    core_if bus ();

    core_mem memory (
        .clk (clk),
        .bus (bus)
    );

    logic [31:0] inst;
    logic [6:0]  opc;
    logic [4:0]  rd, rs1i, rs2i;
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign inst  = bus.idata;
    assign opc   = inst[6:0];
    assign rd    = inst[11:7];
    assign f3    = inst[14:12];
    assign rs1i  = inst[19:15];
    assign rs2i  = inst[24:20];
    assign a     = (rs1i == 5'd0) ? 32'd0 : rs[rs1i];
    assign b     = (rs2i == 5'd0) ? 32'd0 : rs[rs2i];
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                    inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'd0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                    inst[20], inst[30:21], 1'b0};

    logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld;
    logic is_st, is_opi, is_op, is_fence, is_sys;

    assign is_lui   = opc == 7'h37;
    assign is_auipc = opc == 7'h17;
    assign is_jal   = opc == 7'h6f;
    assign is_jalr  = opc == 7'h67;
    assign is_br    = opc == 7'h63;
    assign is_ld    = opc == 7'h03;
    assign is_st    = opc == 7'h23;
    assign is_opi   = opc == 7'h13;
    assign is_op    = opc == 7'h33;
    assign is_fence = opc == 7'h0f;
    assign is_sys   = opc == 7'h73;

    logic [31:0] opb, alu;
    logic [4:0]  sh;

    assign opb = is_op ? b : imm_i;
    assign sh  = opb[4:0];

    always_comb begin
        alu = 32'd0;
        unique case (f3)
            3'd0: alu = (is_op && inst[30]) ? a - opb : a + opb;
            3'd1: alu = a << sh;
            3'd2: alu = {31'd0, $signed(a) < $signed(opb)};
            3'd3: alu = {31'd0, a < opb};
            3'd4: alu = a ^ opb;
            3'd5: alu = inst[30] ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: alu = a | opb;
            3'd7: alu = a & opb;
        endcase
    end

    logic take;

    always_comb begin
        take = 1'b0;
        unique case (f3)
            3'd0:    take = a == b;
            3'd1:    take = a != b;
            3'd4:    take = $signed(a) < $signed(b);
            3'd5:    take = $signed(a) >= $signed(b);
            3'd6:    take = a < b;
            3'd7:    take = a >= b;
            default: take = 1'b0;
        endcase
    end

    logic [31:0] ldv;

    always_comb begin
        ldv = bus.rdata;
        unique case (f3)
            3'd0:    ldv = {{24{bus.rdata[7]}}, bus.rdata[7:0]};
            3'd1:    ldv = {{16{bus.rdata[15]}}, bus.rdata[15:0]};
            3'd4:    ldv = {24'd0, bus.rdata[7:0]};
            3'd5:    ldv = {16'd0, bus.rdata[15:0]};
            default: ldv = bus.rdata;
        endcase
    end

    logic [11:0] caddr;
    logic [31:0] cold, csrc, cnew;

    assign caddr = inst[31:20];
    assign cold  = csr[caddr];
    assign csrc  = f3[2] ? {27'd0, rs1i} : a;

    always_comb begin
        cnew = csrc;
        unique case (f3[1:0])
            2'd2:    cnew = cold | csrc;
            2'd3:    cnew = cold & ~csrc;
            default: cnew = csrc;
        endcase
    end

    logic [31:0] npc, rd_val;
    logic [31:0] cause;
    logic        rd_we, csr_we, trap;
    logic [3:0]  wstrb;

    always_comb begin
        npc    = pc + 32'd4;
        rd_we  = 1'b0;
        rd_val = 32'd0;
        csr_we = 1'b0;
        trap   = 1'b0;
        cause  = 32'd0;
        wstrb  = 4'd0;
        unique case (1'b1)
            is_lui: begin
                rd_we  = 1'b1;
                rd_val = imm_u;
            end
            is_auipc: begin
                rd_we  = 1'b1;
                rd_val = pc + imm_u;
            end
            is_jal: begin
                rd_we  = 1'b1;
                rd_val = pc + 32'd4;
                npc    = pc + imm_j;
            end
            is_jalr: begin
                rd_we  = 1'b1;
                rd_val = pc + 32'd4;
                npc    = (a + imm_i) & ~32'd1;
            end
            is_br: begin
                if (take) npc = pc + imm_b;
            end
            is_ld: begin
                rd_we  = 1'b1;
                rd_val = ldv;
            end
            is_st: begin
                unique case (f3[1:0])
                    2'd0:    wstrb = 4'b0001;
                    2'd1:    wstrb = 4'b0011;
                    default: wstrb = 4'b1111;
                endcase
            end
            is_opi, is_op: begin
                rd_we  = 1'b1;
                rd_val = alu;
            end
            is_fence: begin
                rd_we = 1'b0;
            end
            is_sys: begin
                if (f3 == 3'd0) begin
                    if (caddr == 12'h000) begin
                        trap  = 1'b1;
                        cause = 32'd11;
                    end else if (caddr == 12'h001) begin
                        trap  = 1'b1;
                        cause = 32'd3;
                    end else if (caddr == 12'h302) begin
                        npc = csr[12'h341];
                    end
                end else if (f3 != 3'd4) begin
                    rd_we  = 1'b1;
                    rd_val = cold;
                    // Set/clear with a zero source must leave the CSR alone.
                    csr_we = (f3[1:0] == 2'd1) || (rs1i != 5'd0);
                end
            end
            default: begin
                trap  = 1'b1;
                cause = 32'd2;
            end
        endcase
        if (trap) npc = {csr[12'h305][31:2], 2'b00};
        if (rst) wstrb = 4'd0;
    end

    assign bus.iaddr = pc[15:0];
    assign bus.daddr = a[15:0] + (is_st ? imm_s[15:0] : imm_i[15:0]);
    assign bus.wdata = b;
    assign bus.wstrb = wstrb;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= 32'd0;
            for (int i = 0; i < 32; i++) rs[i] <= 32'd0;
            for (int i = 0; i < 4096; i++) csr[i] <= 32'd0;
        end else begin
            pc <= npc;
            if (rd_we && rd != 5'd0) rs[rd] <= rd_val;
            if (csr_we) csr[caddr] <= cnew;
            if (trap) begin
                csr[12'h341] <= pc;
                csr[12'h342] <= cause;
            end
        end
    end

`ifdef CORE_TRACE_EN
    always @(posedge clk) begin
        if (!rst) begin
            if (rd_we && rd != 5'd0)
                $display("pc=%08h inst=%08h x%0d=%08h", pc, inst, rd, rd_val);
            else
                $display("pc=%08h inst=%08h", pc, inst);
        end
    end
`else
`endif
endmodule

// File: tb/tb_core.sv
// Directed bench for the single-cycle core: hand-assembled program,
// hand-computed architectural state after each group of cycles.
module tb_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    core dut (
        .clk (clk),
        .rst (rst)
    );

    function automatic logic [31:0] i_t(int imm, int r1, int f3, int rd, int op);
        logic [31:0] im, x1, x3, xd, xo;
        im = imm; x1 = r1; x3 = f3; xd = rd; xo = op;
        return {im[11:0], x1[4:0], x3[2:0], xd[4:0], xo[6:0]};
    endfunction

    function automatic logic [31:0] r_t(int f7, int r2, int r1, int f3, int rd);
        logic [31:0] x7, x2, x1, x3, xd;
        x7 = f7; x2 = r2; x1 = r1; x3 = f3; xd = rd;
        return {x7[6:0], x2[4:0], x1[4:0], x3[2:0], xd[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] s_t(int imm, int r2, int r1, int f3);
        logic [31:0] im, x2, x1, x3;
        im = imm; x2 = r2; x1 = r1; x3 = f3;
        return {im[11:5], x2[4:0], x1[4:0], x3[2:0], im[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] b_t(int imm, int r2, int r1, int f3);
        logic [31:0] im, x2, x1, x3;
        im = imm; x2 = r2; x1 = r1; x3 = f3;
        return {im[12], im[10:5], x2[4:0], x1[4:0], x3[2:0],
                im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] u_t(int imm20, int rd, int op);
        logic [31:0] im, xd, xo;
        im = imm20; xd = rd; xo = op;
        return {im[19:0], xd[4:0], xo[6:0]};
    endfunction

    function automatic logic [31:0] j_t(int imm, int rd);
        logic [31:0] im, xd;
        im = imm; xd = rd;
        return {im[20], im[10:1], im[11], im[19:12], xd[4:0], 7'h6f};
    endfunction

    task automatic put(input logic [15:0] adr, input logic [31:0] w);
        for (int k = 0; k < 4; k++) dut.memory.m[adr + 16'(k)] = w[8*k +: 8];
    endtask

    function automatic logic [31:0] memw(input logic [15:0] adr);
        return {dut.memory.m[adr + 16'd3], dut.memory.m[adr + 16'd2],
                dut.memory.m[adr + 16'd1], dut.memory.m[adr]};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    initial begin
        put(16'h00, i_t(-1, 0, 0, 1, 'h13));
        put(16'h04, r_t(0, 0, 1, 2, 3));
        put(16'h08, r_t(0, 0, 1, 3, 4));
        put(16'h0C, i_t('h404, 1, 5, 5, 'h13));
        put(16'h10, j_t(8, 1));
        put(16'h14, i_t(1, 0, 0, 7, 'h13));
        put(16'h18, i_t(5, 0, 0, 0, 'h13));
        put(16'h1C, u_t('h80FF8, 8, 'h37));
        put(16'h20, i_t(-255, 8, 0, 8, 'h13));
        put(16'h24, i_t('h100, 0, 0, 9, 'h13));
        put(16'h28, s_t(0, 8, 9, 2));
        put(16'h2C, i_t(0, 9, 0, 10, 'h03));
        put(16'h30, i_t(3, 9, 4, 11, 'h03));
        put(16'h34, i_t(2, 9, 1, 12, 'h03));
        put(16'h38, b_t(8, 0, 0, 0));
        put(16'h3C, i_t(2, 0, 0, 7, 'h13));
        put(16'h40, b_t(8, 0, 1, 0));
        put(16'h44, i_t('h83, 0, 0, 13, 'h13));
        put(16'h48, i_t('h305, 13, 1, 0, 'h73));
        put(16'h4C, 32'h00000073);
        put(16'h50, 32'h00100073);
        put(16'h54, 32'h00000000);
        put(16'h58, j_t(0, 0));
        put(16'h80, i_t('h342, 0, 2, 14, 'h73));
        put(16'h84, i_t('h341, 0, 2, 15, 'h73));
        put(16'h88, i_t(4, 15, 0, 15, 'h13));
        put(16'h8C, i_t('h341, 15, 1, 0, 'h73));
        put(16'h90, 32'h30200073);

        rst = 1'b1;
        tick(1);
        chk("reset_pc", dut.pc, 32'h0);
        for (int i = 1; i < 32; i++) chk($sformatf("reset_x%0d", i), dut.rs[i], 32'h0);
        chk("reset_mtvec", dut.csr[12'h305], 32'h0);
        chk("reset_mem0", memw(16'h0), 32'hFFF00093);
        rst = 1'b0;

        tick(4);
        chk("pc_10", dut.pc, 32'h10);
        chk("addi_m1", dut.rs[1], 32'hFFFFFFFF);
        chk("slt", dut.rs[3], 32'h1);
        chk("sltu", dut.rs[4], 32'h0);
        chk("srai", dut.rs[5], 32'hFFFFFFFF);

        tick(1);
        chk("jal_pc", dut.pc, 32'h18);
        chk("jal_link", dut.rs[1], 32'h14);

        tick(1);
        chk("x0_write", dut.rs[0], 32'h0);
        chk("jal_skip", dut.rs[7], 32'h0);

        tick(3);
        chk("pc_28", dut.pc, 32'h28);
        chk("lui_addi", dut.rs[8], 32'h80FF7F01);

        tick(1);
        chk("sw_mem", memw(16'h100), 32'h80FF7F01);

        tick(3);
        chk("pc_38", dut.pc, 32'h38);
        chk("lb", dut.rs[10], 32'h00000001);
        chk("lbu", dut.rs[11], 32'h00000080);
        chk("lh", dut.rs[12], 32'hFFFF80FF);

        tick(1);
        chk("beq_taken", dut.pc, 32'h40);
        tick(1);
        chk("beq_not_taken", dut.pc, 32'h44);
        chk("beq_skip", dut.rs[7], 32'h0);

        tick(2);
        chk("csrw_mtvec", dut.csr[12'h305], 32'h83);

        tick(1);
        chk("ecall_pc", dut.pc, 32'h80);
        chk("ecall_mepc", dut.csr[12'h341], 32'h4C);
        chk("ecall_mcause", dut.csr[12'h342], 32'd11);

        tick(5);
        chk("mret_pc", dut.pc, 32'h50);
        chk("csrr_mcause", dut.rs[14], 32'd11);
        chk("csrr_mepc", dut.rs[15], 32'h50);

        tick(1);
        chk("ebreak_pc", dut.pc, 32'h80);
        chk("ebreak_mcause", dut.csr[12'h342], 32'd3);
        chk("ebreak_mepc", dut.csr[12'h341], 32'h50);

        tick(6);
        chk("illegal_pc", dut.pc, 32'h80);
        chk("illegal_mcause", dut.csr[12'h342], 32'd2);
        chk("illegal_mepc", dut.csr[12'h341], 32'h54);

        tick(5);
        chk("mret2_pc", dut.pc, 32'h58);
        tick(2);
        chk("loop_pc", dut.pc, 32'h58);

        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rerst_pc", dut.pc, 32'h0);
        chk("rerst_x14", dut.rs[14], 32'h0);
        chk("rerst_mcause", dut.csr[12'h342], 32'h0);
        chk("rerst_mem", memw(16'h100), 32'h80FF7F01);

        tick(1);
        chk("rerun_pc", dut.pc, 32'h4);
        chk("rerun_x1", dut.rs[1], 32'hFFFFFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
